// File: rtl/bist_sequencer.sv
// bist_sequencer: logic-BIST run controller (LFSR seed, shift/capture patterns, flush, signature compare).
// Optional macro BIST_ABORT_EN: ABORT forces an in-flight run to DONE with a fail result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for START, last result held on PASS_FAIL/PAT_CNT
// S_SEED    | one cycle: LFSR seed load + MISR clear
// S_SHIFT   | CHAIN_LEN cycles of scan shift with compaction
// S_CAPTURE | one functional capture cycle, pattern count advances
// S_FLUSH   | CHAIN_LEN cycles unloading the final captured response
// S_COMPARE | one cycle: comparator strobe, SIG_MATCH latched
// S_DONE    | BIST_END held until START drops
module bist_sequencer #(
   parameter int  CHAIN_LEN  = 8,
   parameter int  N_PATTERNS = 32,
   localparam int PW         = $clog2(N_PATTERNS + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          ABORT,
   input  logic          SIG_MATCH,
   output logic          SCAN_EN,
   output logic          SEED,
   output logic          MISR_CLR,
   output logic          MISR_EN,
   output logic          CMP_STROBE,
   output logic          RUNNING,
   output logic          BIST_END,
   output logic          PASS_FAIL,
   output logic [PW-1:0] PAT_CNT
);

   localparam int SW = $clog2(CHAIN_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEED    = 3'd1,
      S_SHIFT   = 3'd2,
      S_CAPTURE = 3'd3,
      S_FLUSH   = 3'd4,
      S_COMPARE = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] shift_cnt;
   logic [PW-1:0] pat_cnt;
   logic          pass_fail;
   logic          shift_last;
   logic          pat_last;
   logic          abort_hit;

   assign shift_last = (shift_cnt == SW'(CHAIN_LEN - 1));
   assign pat_last   = (pat_cnt == PW'(N_PATTERNS - 1));

`ifndef BIST_ABORT_EN
   logic unused_abort;
   assign unused_abort = ABORT;
`endif

   always_comb begin
      state_nxt = state;
      abort_hit = 1'b0;
      case (state)
         S_IDLE:    if (START) state_nxt = S_SEED;
         S_SEED:    state_nxt = S_SHIFT;
         S_SHIFT:   if (shift_last) state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = pat_last ? S_FLUSH : S_SHIFT;
         S_FLUSH:   if (shift_last) state_nxt = S_COMPARE;
         S_COMPARE: state_nxt = S_DONE;
         S_DONE:    if (!START) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
`ifdef BIST_ABORT_EN
      // abort overrides every in-run transition, including COMPARE -> DONE
      if (ABORT && (state != S_IDLE) && (state != S_DONE)) begin
         abort_hit = 1'b1;
         state_nxt = S_DONE;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         shift_cnt <= '0;
         pat_cnt   <= '0;
         pass_fail <= 1'b0;
      end else begin
         state <= state_nxt;
         // counter restarts on every entry into SHIFT/FLUSH
         if (((state == S_SHIFT) || (state == S_FLUSH)) && (state_nxt == state))
            shift_cnt <= shift_cnt + SW'(1);
         else
            shift_cnt <= '0;
         if (state == S_SEED)
            pat_cnt <= '0;
         else if ((state == S_CAPTURE) && !abort_hit)
            pat_cnt <= pat_cnt + PW'(1);
         if ((state == S_SEED) || abort_hit)
            pass_fail <= 1'b0;
         else if (state == S_COMPARE)
            pass_fail <= SIG_MATCH;
      end
   end

   always_comb begin
      SCAN_EN    = 1'b0;
      SEED       = 1'b0;
      MISR_CLR   = 1'b0;
      MISR_EN    = 1'b0;
      CMP_STROBE = 1'b0;
      RUNNING    = 1'b0;
      BIST_END   = 1'b0;
      case (state)
         S_SEED: begin
            SEED     = 1'b1;
            MISR_CLR = 1'b1;
            RUNNING  = 1'b1;
         end
         S_SHIFT, S_FLUSH: begin
            SCAN_EN = 1'b1;
            MISR_EN = 1'b1;
            RUNNING = 1'b1;
         end
         S_CAPTURE: begin
            MISR_EN = 1'b1;
            RUNNING = 1'b1;
         end
         S_COMPARE: begin
            CMP_STROBE = 1'b1;
            RUNNING    = 1'b1;
         end
         S_DONE:  BIST_END = 1'b1;
         default: ;
      endcase
   end

   assign PASS_FAIL = pass_fail;
   assign PAT_CNT   = pat_cnt;

endmodule

// File: tb/tb_bist_sequencer.sv
// Testbench for bist_sequencer: default-size instance plus a CHAIN_LEN=1/N_PATTERNS=1 instance,
// every cycle checked against a cycle-offset reference model.
module tb_bist_sequencer;

   localparam int L = 8;
   localparam int N = 32;

   logic clk = 1'b0;
   logic rst, start, abort_in, sig_match, start_s;

   logic       scan_en, seed, misr_clr, misr_en, cmp_strobe, running, bist_end, pass_fail;
   logic [5:0] pat_cnt;
   logic       s_scan_en, s_seed, s_misr_clr, s_misr_en, s_cmp_strobe, s_running, s_bist_end, s_pass_fail;
   logic [0:0] s_pat_cnt;

   int total = 0;
   int bad   = 0;
   logic last_pf;
   int   last_pat;

   always #5 clk = ~clk;

   bist_sequencer #(.CHAIN_LEN(L), .N_PATTERNS(N)) dut (
      .CLK(clk), .RST(rst), .START(start), .ABORT(abort_in), .SIG_MATCH(sig_match),
      .SCAN_EN(scan_en), .SEED(seed), .MISR_CLR(misr_clr), .MISR_EN(misr_en),
      .CMP_STROBE(cmp_strobe), .RUNNING(running), .BIST_END(bist_end),
      .PASS_FAIL(pass_fail), .PAT_CNT(pat_cnt)
   );

   bist_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1)) dut_small (
      .CLK(clk), .RST(rst), .START(start_s), .ABORT(abort_in), .SIG_MATCH(sig_match),
      .SCAN_EN(s_scan_en), .SEED(s_seed), .MISR_CLR(s_misr_clr), .MISR_EN(s_misr_en),
      .CMP_STROBE(s_cmp_strobe), .RUNNING(s_running), .BIST_END(s_bist_end),
      .PASS_FAIL(s_pass_fail), .PAT_CNT(s_pat_cnt)
   );

   logic [6:0] big_v, small_v;
   assign big_v   = {scan_en, seed, misr_clr, misr_en, cmp_strobe, running, bist_end};
   assign small_v = {s_scan_en, s_seed, s_misr_clr, s_misr_en, s_cmp_strobe, s_running, s_bist_end};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output vector {scan,seed,clr,men,strobe,running,end} k edges after START was accepted.
   function automatic void model(input int k, input int cl, input int np, input int pat_old,
                                 output logic [6:0] v, output int pat);
      int r, pos;
      if (k == 0) begin
         v   = 7'b0110010;
         pat = pat_old;
      end else begin
         r = k - 1;
         if (r < np * (cl + 1)) begin
            pos = r % (cl + 1);
            pat = r / (cl + 1);
            v   = (pos < cl) ? 7'b1001010 : 7'b0001010;
         end else begin
            r   = r - np * (cl + 1);
            pat = np;
            if (r < cl)       v = 7'b1001010;
            else if (r == cl) v = 7'b0000110;
            else              v = 7'b0000001;
         end
      end
   endfunction

   task automatic check_big(input string tag, input int k, input logic pf_exp, input int pat_old);
      logic [6:0] v;
      int         pat;
      model(k, L, N, pat_old, v, pat);
      chk($sformatf("%s k=%0d outs", tag, k), {25'b0, big_v}, {25'b0, v});
      chk($sformatf("%s k=%0d pat_cnt", tag, k), 32'(pat_cnt), pat);
      chk($sformatf("%s k=%0d pass_fail", tag, k), {31'b0, pass_fail}, {31'b0, pf_exp});
   endtask

   task automatic check_idle(input string tag, input logic pf_exp, input int pat_exp);
      chk({tag, " outs"}, {25'b0, big_v}, 32'd0);
      chk({tag, " pat_cnt"}, 32'(pat_cnt), pat_exp);
      chk({tag, " pass_fail"}, {31'b0, pass_fail}, {31'b0, pf_exp});
   endtask

   // mode: 0/1 = fixed SIG_MATCH, 2 = random; stop_at > 0 returns mid-run after that offset
   task automatic run_big(input int mode, input bit toggle, input int stop_at);
      int   t;
      int   hold;
      logic m;
      t = 1 + N * (L + 1) + L + 1;
      m = 1'b0;
      start     = 1'b1;
      sig_match = ($urandom & 1) != 0;
      step();
      check_big("run", 0, last_pf, last_pat);
      for (int k = 1; k <= t; k++) begin
         if (toggle) start = ($urandom & 1) != 0;
         sig_match = (mode == 2) ? (($urandom & 1) != 0) : mode[0];
         if (k == t) m = sig_match;
`ifndef BIST_ABORT_EN
         abort_in = ($urandom & 1) != 0;
`endif
         step();
         check_big("run", k, (k < t) ? 1'b0 : m, last_pat);
         if (stop_at > 0 && k == stop_at) return;
      end
      chk("end_edge", 32'(t), 32'(1 + N * (L + 1) + L + 1));
      start = 1'b1;
      hold  = $urandom_range(1, 4);
      for (int i = 0; i < hold; i++) begin
         step();
         check_big("hold_done", t + 1, m, last_pat);
      end
      start = 1'b0;
      abort_in = 1'b0;
      step();
      check_idle("release", m, N);
      step();
      check_idle("idle_hold", m, N);
      last_pf  = m;
      last_pat = N;
   endtask

   initial begin
      logic [6:0] v;
      int         pat;
      logic       m;
      rst = 1'b1; start = 1'b0; abort_in = 1'b0; sig_match = 1'b0; start_s = 1'b0;
      last_pf = 1'b0; last_pat = 0;
      step(); step();
      check_idle("reset", 1'b0, 0);
      chk("reset small outs", {25'b0, small_v}, 32'd0);
      rst = 1'b0;
      step();
      check_idle("post_reset", 1'b0, 0);

      run_big(1, 1'b0, 0);
      run_big(0, 1'b0, 0);
      run_big(2, 1'b1, 0);

      // reset held two cycles in the middle of SHIFT, START held high throughout
      run_big(2, 1'b0, 20);
      rst = 1'b1; start = 1'b1;
      step();
      check_idle("midrun_reset1", 1'b0, 0);
      step();
      check_idle("midrun_reset2", 1'b0, 0);
      rst = 1'b0; start = 1'b0;
      step();
      check_idle("after_reset", 1'b0, 0);
      last_pf = 1'b0; last_pat = 0;
      run_big(2, 1'b1, 0);

`ifdef BIST_ABORT_EN
      run_big(1, 1'b0, 50);
      abort_in = 1'b1;
      step();
      abort_in = 1'b0;
      model(50, L, N, last_pat, v, pat);
      chk("abort outs", {25'b0, big_v}, 32'b0000001);
      chk("abort pass_fail", {31'b0, pass_fail}, 32'd0);
      chk("abort pat_cnt", 32'(pat_cnt), pat);
      start = 1'b0;
      step();
      check_idle("abort_release", 1'b0, pat);
      last_pf = 1'b0; last_pat = pat;
`endif

      // minimum-size instance: CHAIN_LEN=1, N_PATTERNS=1 -> BIST_END at edge 5
      m = 1'b0;
      start_s = 1'b1;
      step();
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) begin
            sig_match = ($urandom & 1) != 0;
            if (k == 5) m = sig_match;
            step();
         end
         model(k, 1, 1, 0, v, pat);
         chk($sformatf("small k=%0d outs", k), {25'b0, small_v}, {25'b0, v});
         chk($sformatf("small k=%0d pat_cnt", k), 32'(s_pat_cnt), pat);
         chk($sformatf("small k=%0d pass_fail", k), {31'b0, s_pass_fail}, (k < 5) ? 32'd0 : {31'b0, m});
      end
      start_s = 1'b0;
      step();
      chk("small release outs", {25'b0, small_v}, 32'd0);
      chk("small release pat_cnt", 32'(s_pat_cnt), 32'd1);
      chk("small release pass_fail", {31'b0, s_pass_fail}, {31'b0, m});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
